// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with iterative one-bit-per-cycle arithmetic right shift
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] res_c, sreg, sh_next;
  logic [SHW-1:0] cnt;
  logic zero_c;
  always_comb begin
    res_c = ctrl_i == 4'b0000 ? src1_i & src2_i :
            ctrl_i == 4'b0001 ? src1_i | src2_i :
            ctrl_i == 4'b0010 ? src1_i + src2_i :
            ctrl_i == 4'b0110 ? src1_i - src2_i :
            ctrl_i == 4'b0111 ? WIDTH'($signed(src1_i) < $signed(src2_i)) :
            ctrl_i == 4'b1000 ? src1_i :
            ctrl_i == 4'b1001 ? {src2_i[15:0], {(WIDTH-16){1'b0}}} :
            ctrl_i == 4'b1010 ? src1_i - src2_i : '0;
    zero_c = ctrl_i == 4'b1010 ? |res_c : ~|res_c;
    sh_next = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      result_o <= '0;
      zero_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      sreg <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          if (ctrl_i == 4'b1000 && shamt_i != '0) begin
            sreg <= src1_i;
            cnt <= shamt_i;
            busy_o <= 1'b1;
            state <= SHIFT;
          end else begin
            result_o <= res_c;
            zero_o <= zero_c;
            done_o <= 1'b1;
            state <= DONE;
          end
        end
        SHIFT: begin
          sreg <= sh_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            result_o <= sh_next;
            zero_o <= ~|sh_next;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors with hand-computed results for alu_iter
module tb_alu_iter;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] ctrl = 0;
  logic [31:0] src1 = 0, src2 = 0, result;
  logic [4:0] shamt = 0;
  logic zero, busy, done;
  int errors = 0, checks = 0;
  alu_iter dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
    .result_o(result), .zero_o(zero), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] sh, input logic [31:0] exp_r, input logic exp_z, input int exp_cyc);
    int cyc = 0, bcyc = 0, extra = 0;
    logic both = 0;
    ctrl = c; src1 = a; src2 = b; shamt = sh; start = 1;
    do begin
      step();
      cyc++;
      if (cyc == 1) begin
        src1 = ~a; src2 = ~b; shamt = 5'd0; ctrl = 4'b0011;
      end
      if (busy) bcyc++;
      if (busy && done) both = 1;
    end while (!done && cyc < 40);
    start = 0;
    check({tag, " result"}, result, exp_r);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_z});
    check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " busy cycles"}, bcyc, exp_cyc - 1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || busy) extra++;
    end
    check({tag, " stray done/busy"}, extra, 0);
    check({tag, " busy&done"}, {31'd0, both}, 32'd0);
  endtask
  initial begin
    int seen;
    start = 1; ctrl = 4'b0010; src1 = 1; src2 = 1;
    repeat (3) step();
    check("reset result", result, 0);
    check("reset flags", {zero, busy, done}, 3'b000);
    rst = 0; start = 0;
    seen = 0;
    repeat (3) begin step(); if (done || busy) seen++; end
    check("idle after reset", seen, 0);
    op("ADD wrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 1'b1, 1);
    op("SUB", 4'b0110, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0, 1);
    op("AND", 4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 1'b0, 1);
    op("OR", 4'b0001, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 1'b0, 1);
    op("SLT neg", 4'b0111, 32'h80000000, 32'd1, 5'd0, 32'd1, 1'b0, 1);
    op("SLT ovf", 4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 1);
    op("LUI", 4'b1001, 32'h12345678, 32'h0000ABCD, 5'd0, 32'hABCD0000, 1'b0, 1);
    op("BNE eq", 4'b1010, 32'h1234, 32'h1234, 5'd0, 32'h0, 1'b0, 1);
    op("BNE ne", 4'b1010, 32'd3, 32'd4, 5'd0, 32'hFFFFFFFF, 1'b1, 1);
    op("undef code", 4'b0011, 32'h5, 32'h6, 5'd0, 32'h0, 1'b1, 1);
    op("SHR 4", 4'b1000, 32'h80000010, 32'h0, 5'd4, 32'hF8000001, 1'b0, 5);
    op("SHR 0", 4'b1000, 32'h80000010, 32'h0, 5'd0, 32'h80000010, 1'b0, 1);
    op("SHR 31", 4'b1000, 32'h80000010, 32'h0, 5'd31, 32'hFFFFFFFF, 1'b0, 32);
    op("SHR pos", 4'b1000, 32'h40000000, 32'h0, 5'd3, 32'h08000000, 1'b0, 4);
    ctrl = 4'b1000; src1 = 32'h80000010; shamt = 5'd10; start = 1;
    step();
    start = 0;
    check("abort busy", {31'd0, busy}, 32'd1);
    step(); step();
    rst = 1;
    step();
    check("abort result", result, 0);
    check("abort flags", {zero, busy, done}, 3'b000);
    rst = 0;
    seen = 0;
    repeat (12) begin step(); if (done || busy) seen++; end
    check("abort no done", seen, 0);
    op("ADD after abort", 4'b0010, 32'd100, 32'd23, 5'd0, 32'd123, 1'b0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
